// File: rtl/button_accum_pkg.sv
// Shared definitions for the button accumulator controller: the per-channel
// state encoding, the default parameter values and an index-width helper.
// Optional feature macro: BUTTON_ACCUM_AUTO_REPEAT_EN (auto-repeat pulses).
package button_accum_pkg;

  // Encoding keeps one register bit per non-idle state, so "held" and
  // "debouncing" can be read straight off a flop bit.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DEB  = 2'b01,
    ST_HELD = 2'b10
  } state_e;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_DEB_CYC    = 4;
  localparam int DEF_REPEAT_CYC = 16;
  localparam int DEF_CNT_W      = 8;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_accum_ctrl_press_ch_fsm.sv
// One press channel: IDLE -> DEB -> HELD state machine with its debounce
// counter and registered press pulse. Arbitration happens at the top level;
// this block only enters DEB when granted.
module press_ch_fsm
  import button_accum_pkg::*;
#(
  parameter int DEB_CYC = DEF_DEB_CYC
) (
  input  logic clk,
  input  logic reset_i,
  input  logic pressed_i,
  input  logic grant_i,      // won arbitration this cycle (implies pressed)
  input  logic rep_tick_i,   // repeat period elapsed; only honoured in HELD
  output logic busy_d_o,     // next-state "not idle", for the registered busy
  output logic enter_held_o, // DEB -> HELD transition at the coming edge
  output logic stay_held_o,  // HELD -> HELD transition at the coming edge
  output logic held_o,
  output logic pulse_o
);

  localparam int CW = idx_w(DEB_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pulse_q, pulse_d;

  // Next-state logic: debounce counting, press qualification and release.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pulse_d      = 1'b0;
    enter_held_o = 1'b0;
    stay_held_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_i) begin
          state_d = ST_DEB;
          cnt_d   = '0;
        end
      end
      ST_DEB: begin
        if (!pressed_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = ST_HELD;
          pulse_d      = 1'b1;
          enter_held_o = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HELD: begin
        if (!pressed_i) begin
          state_d = ST_IDLE;
        end else begin
          stay_held_o = 1'b1;
          pulse_d     = rep_tick_i;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and pulse registers; reset wins over any input.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign busy_d_o = (state_d != ST_IDLE);
  assign held_o   = state_q[1];
  assign pulse_o  = pulse_q;

endmodule

// File: rtl/button_accum_ctrl.sv
// Button / coin accumulator controller: NUM_CH debounced press channels with
// single-owner lockout, hold-duration counter and optional auto-repeat.
// Optional feature macro: BUTTON_ACCUM_AUTO_REPEAT_EN adds repeat pulses every
// REPEAT_CYC held cycles; without it each qualified press pulses once.
module button_accum_ctrl
  import button_accum_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DEB_CYC    = DEF_DEB_CYC,
  parameter int REPEAT_CYC = DEF_REPEAT_CYC,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset_i,
  input  logic [NUM_CH-1:0]         pressed_i,
  output logic [NUM_CH-1:0]         enable_o,
  output logic [NUM_CH-1:0]         press_pulse_o,
  output logic                      busy_o,
  output logic [idx_w(NUM_CH)-1:0]  active_ch_o,
  output logic [CNT_W-1:0]          hold_cnt_o
);

  localparam int AW = idx_w(NUM_CH);

  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] busy_d;
  logic [NUM_CH-1:0] enter_held;
  logic [NUM_CH-1:0] stay_held;
  logic [AW-1:0]     win_idx;
  logic              win_found;
  logic              rep_tick;

  logic              busy_q;
  logic [AW-1:0]     active_q, active_d;
  logic [CNT_W-1:0]  hold_q, hold_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Lockout arbitration: only when nobody owns the lock, lowest index wins.
  always_comb begin
    grant     = '0;
    win_idx   = '0;
    win_found = 1'b0;
    if (!busy_q) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (pressed_i[i] && !win_found) begin
          grant[i]  = 1'b1;
          win_idx   = AW'(i);
          win_found = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    press_ch_fsm #(
      .DEB_CYC (DEB_CYC)
    ) u_ch (
      .clk          (clk),
      .reset_i      (reset_i),
      .pressed_i    (pressed_i[g]),
      .grant_i      (grant[g]),
      .rep_tick_i   (rep_tick),
      .busy_d_o     (busy_d[g]),
      .enter_held_o (enter_held[g]),
      .stay_held_o  (stay_held[g]),
      .held_o       (enable_o[g]),
      .pulse_o      (press_pulse_o[g])
    );
  end

`ifdef BUTTON_ACCUM_AUTO_REPEAT_EN
  localparam int RW = idx_w(REPEAT_CYC);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYC - 1);

  logic [RW-1:0] rep_q, rep_d;

  // Repeat phase within HELD; independent of the saturating hold counter.
  always_comb begin
    rep_d = rep_q;
    if (|enter_held) begin
      rep_d = '0;
    end else if (|stay_held) begin
      rep_d = (rep_q == REP_LAST) ? '0 : rep_q + RW'(1);
    end
  end

  // Repeat phase register.
  always_ff @(posedge clk) begin
    if (reset_i) rep_q <= '0;
    else         rep_q <= rep_d;
  end

  assign rep_tick = (rep_q == REP_LAST);
`else
  assign rep_tick = 1'b0;
`endif

  // Owner index and hold-duration counter next-state.
  always_comb begin
    active_d = win_found ? win_idx : active_q;
    hold_d   = hold_q;
    if (|enter_held) begin
      hold_d = CNT_W'(1);
    end else if (|stay_held) begin
      hold_d = sat_inc(hold_q);
    end
  end

  // Registered shared outputs.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      busy_q   <= 1'b0;
      active_q <= '0;
      hold_q   <= '0;
    end else begin
      busy_q   <= |busy_d;
      active_q <= active_d;
      hold_q   <= hold_d;
    end
  end

  assign busy_o      = busy_q;
  assign active_ch_o = active_q;
  assign hold_cnt_o  = hold_q;

endmodule

// File: tb/tb_button_accum_ctrl.sv
// Scoreboard bench for button_accum_ctrl (NUM_CH=4, DEB_CYC=4, REPEAT_CYC=16,
// CNT_W=4). Directed scenarios followed by randomized press patterns.
module tb_button_accum_ctrl;

  localparam int NCH = 4;
  localparam int DEB = 4;
  localparam int REP = 16;
  localparam int CW  = 4;

  typedef struct packed {
    logic [NCH-1:0] en;
    logic [NCH-1:0] pulse;
    logic           busy;
    logic [1:0]     act;
    logic [CW-1:0]  hold;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset_i = 1'b1;
  logic [NCH-1:0] pressed_i = '0;
  logic [NCH-1:0] enable_o;
  logic [NCH-1:0] press_pulse_o;
  logic           busy_o;
  logic [1:0]     active_ch_o;
  logic [CW-1:0]  hold_cnt_o;

  button_accum_ctrl #(
    .NUM_CH     (NCH),
    .DEB_CYC    (DEB),
    .REPEAT_CYC (REP),
    .CNT_W      (CW)
  ) dut (
    .clk           (clk),
    .reset_i       (reset_i),
    .pressed_i     (pressed_i),
    .enable_o      (enable_o),
    .press_pulse_o (press_pulse_o),
    .busy_o        (busy_o),
    .active_ch_o   (active_ch_o),
    .hold_cnt_o    (hold_cnt_o)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Reference model: who owns the lock and how many consecutive high samples
  // it has seen since it took the lock.
  int             owner = -1;
  int             run = 0;
  logic [CW-1:0]  m_hold = '0;
  logic [1:0]     m_act = '0;

  task automatic model_step(input logic [NCH-1:0] p, input logic r);
    exp_t e;
    int   n;
    e.pulse = '0;
    if (r) begin
      owner = -1; run = 0; m_hold = '0; m_act = '0;
    end else if (owner < 0) begin
      for (int i = 0; i < NCH; i++)
        if (p[i] && owner < 0) begin
          owner = i; run = 1; m_act = 2'(i);
        end
    end else if (!p[owner]) begin
      owner = -1; run = 0;
    end else begin
      run = run + 1;
      n = run - DEB;               // held-cycle number, entry cycle is 1
      if (n == 1) begin
        m_hold = 1;
        e.pulse[owner] = 1'b1;
      end else if (n > 1) begin
        if (m_hold != {CW{1'b1}}) m_hold = m_hold + 1'b1;
`ifdef BUTTON_ACCUM_AUTO_REPEAT_EN
        if ((n - 1) % REP == 0) e.pulse[owner] = 1'b1;
`endif
      end
    end
    e.en   = (owner >= 0 && run > DEB) ? NCH'(1 << owner) : '0;
    e.busy = (owner >= 0);
    e.act  = m_act;
    e.hold = m_hold;
    exp_q.push_back(e);
  endtask

  task automatic apply(input logic [NCH-1:0] p, input logic r, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      pressed_i = p;
      reset_i   = r;
      model_step(p, r);
    end
  endtask

  // Monitor: after every active edge, compare the DUT against the oldest
  // expectation the stimulus side queued.
  initial begin
    exp_t e;
    logic bad;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        bad = 1'b0;
        if (enable_o !== e.en) begin
          bad = 1'b1;
          $display("FAIL cyc %0d enable_o: got %b expected %b", cyc, enable_o, e.en);
        end
        if (press_pulse_o !== e.pulse) begin
          bad = 1'b1;
          $display("FAIL cyc %0d press_pulse_o: got %b expected %b", cyc, press_pulse_o, e.pulse);
        end
        if (busy_o !== e.busy) begin
          bad = 1'b1;
          $display("FAIL cyc %0d busy_o: got %b expected %b", cyc, busy_o, e.busy);
        end
        if (active_ch_o !== e.act) begin
          bad = 1'b1;
          $display("FAIL cyc %0d active_ch_o: got %0d expected %0d", cyc, active_ch_o, e.act);
        end
        if (hold_cnt_o !== e.hold) begin
          bad = 1'b1;
          $display("FAIL cyc %0d hold_cnt_o: got %0d expected %0d", cyc, hold_cnt_o, e.hold);
        end
        if (bad) miscompares++;
      end
    end
  end

  initial begin
    logic [NCH-1:0] p;
    int wait_cyc;
    apply(4'b0000, 1'b1, 2);
    // Single press on ch1, qualified then released.
    apply(4'b0010, 1'b0, 8);
    apply(4'b0000, 1'b0, 2);
    // ch0 and ch2 together: ch0 owns, ch2 waits and takes over after release.
    apply(4'b0101, 1'b0, 8);
    apply(4'b0100, 1'b0, 8);
    apply(4'b0000, 1'b0, 2);
    // Short bounce on ch3: never qualifies.
    apply(4'b1000, 1'b0, 3);
    apply(4'b0000, 1'b0, 3);
    // Long hold on ch1: hold counter saturation and repeat pulses.
    apply(4'b0010, 1'b0, DEB + 1 + 40);
    apply(4'b0000, 1'b0, 3);
    // Reset in the third held cycle while ch2 stays pressed.
    apply(4'b0100, 1'b0, DEB + 3);
    apply(4'b0100, 1'b1, 1);
    apply(4'b0100, 1'b0, DEB + 4);
    apply(4'b0000, 1'b0, 2);
    // Randomized press patterns with slow-changing levels and rare resets.
    p = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < NCH; b++)
        if ($urandom_range(0, 9) == 0) p[b] = ~p[b];
      apply(p, ($urandom_range(0, 299) == 0), 1);
    end
    apply(4'b0000, 1'b0, 2);
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
